// File: rtl/raster_pkg.sv
// raster_pkg: shared widths, iterator states and subsample step lookup for the raster iterator
package raster_pkg;
  localparam int SIGFIG = 24;
  localparam int RADIX = 10;
  localparam int VERTS = 3;
  localparam int AXIS = 3;
  localparam int COLORS = 3;
  localparam int LANES = 4;
  typedef enum logic {WAIT, TEST} iter_state_e;
  function automatic logic signed [SIGFIG-1:0] sample_step(input logic [3:0] sub_sample);
    return SIGFIG'(1) << (sub_sample[3] ? RADIX : sub_sample[2] ? RADIX - 1 :
                          sub_sample[1] ? RADIX - 2 : RADIX - 3);
  endfunction
endpackage

// File: rtl/quad_lane_gen.sv
// quad_lane_gen: positions, valid mask and row/box end flags for one group of four samples
module quad_lane_gen
  import raster_pkg::*;
(
  input  logic signed [SIGFIG-1:0]             xb,
  input  logic signed [SIGFIG-1:0]             y,
  input  logic signed [SIGFIG-1:0]             step,
  input  logic signed [SIGFIG-1:0]             ur_x,
  input  logic signed [SIGFIG-1:0]             ur_y,
  output logic        [LANES-1:0][SIGFIG-1:0] x,
  output logic        [LANES-1:0]             mask,
  output logic                                row_end,
  output logic                                last_grp
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [SIGFIG-1:0] xi;
    assign xi = xb + step * $signed(SIGFIG'(i));
    assign x[i] = xi;
    assign mask[i] = (i == 0) || (xi <= ur_x);
  end
  assign row_end = (xb + (step <<< 2)) > ur_x;
  assign last_grp = row_end && ((y + step) > ur_y);
endmodule

// File: rtl/quad_sample_iterator.sv
// quad_sample_iterator: walks a triangle's bounding box four subsamples per cycle, R13 -> R14
module quad_sample_iterator
  import raster_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
  input  logic                                         validTri_R13H,
  input  logic        [3:0]                             subSample_RnnnnU,
  output logic                                         halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  output logic signed [1:0][LANES-1:0][SIGFIG-1:0]      sample_R14S,
  output logic        [LANES-1:0]                       validSamp_R14H
);
  iter_state_e state, state_nxt;
  logic signed [SIGFIG-1:0] step, ll_x, ur_x, ur_y, xb, y, nxt_x, nxt_y, gen_ur_x, gen_ur_y;
  logic [LANES-1:0][SIGFIG-1:0] lane_x;
  logic [LANES-1:0] mask;
  logic row_end, last_grp, row_end_q, last_q, accept, go;
  // The displayed group doubles as the walk position, so no separate counters are kept.
  assign xb = sample_R14S[0][0];
  assign y = sample_R14S[1][0];
  assign step = sample_step(subSample_RnnnnU);
  always_comb begin
    halt_RnnnnL = (state == WAIT) || (state == TEST && last_q);
    accept = validTri_R13H && halt_RnnnnL;
    go = accept || (state == TEST && !last_q);
    state_nxt = go ? TEST : WAIT;
    nxt_x = accept ? box_R13S[0][0] : row_end_q ? ll_x : xb + (step <<< 2);
    nxt_y = accept ? box_R13S[0][1] : row_end_q ? y + step : y;
    gen_ur_x = accept ? box_R13S[1][0] : ur_x;
    gen_ur_y = accept ? box_R13S[1][1] : ur_y;
  end
  quad_lane_gen u_lane_gen (
    .xb      (nxt_x),
    .y       (nxt_y),
    .step    (step),
    .ur_x    (gen_ur_x),
    .ur_y    (gen_ur_y),
    .x       (lane_x),
    .mask    (mask),
    .row_end (row_end),
    .last_grp(last_grp)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tri_R14S <= '0;
      color_R14U <= '0;
      sample_R14S <= '0;
      validSamp_R14H <= '0;
      ll_x <= '0;
      ur_x <= '0;
      ur_y <= '0;
      row_end_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      validSamp_R14H <= go ? mask : '0;
      if (accept) begin
        tri_R14S <= tri_R13S;
        color_R14U <= color_R13U;
        ll_x <= box_R13S[0][0];
        ur_x <= box_R13S[1][0];
        ur_y <= box_R13S[1][1];
      end
      if (go) begin
        sample_R14S[0] <= lane_x;
        sample_R14S[1] <= {LANES{nxt_y}};
        row_end_q <= row_end;
        last_q <= last_grp;
      end
    end
  end
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(subSample_RnnnnU));
  a_stable: assert property (@(posedge clk) disable iff (rst)
    (state == TEST && !last_q) |=> $stable(subSample_RnnnnU));
endmodule
